// File: rtl/updown_btn_ctrl_pkg.sv
// Shared types and constants for the up/down button control stage.
package updown_btn_ctrl_pkg;

    localparam int unsigned SYNC_STAGES = 2;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_e;

endpackage

// File: rtl/updown_btn_ctrl_debounce.sv
// Two-flop synchroniser plus stability counter for one raw push-button.
module btn_debounce
    import updown_btn_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_db
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_db;
    logic                   w_sync;

    assign w_sync = r_sync[SYNC_STAGES-1];

    // Level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_db   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
            if (w_sync != r_db) begin
                if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db  <= ~r_db;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign btn_db = r_db;

endmodule

// File: rtl/updown_btn_ctrl.sv
// Turns debounced up/down buttons into single-cycle step pulses with
// auto-repeat for the downstream up/down counter.
module updown_btn_ctrl
    import updown_btn_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 256,
    parameter int unsigned REPEAT_PERIOD   = 64,
    parameter int unsigned CNT_W           = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_dn,
    output logic enable,
    output logic direction,
    output logic locked
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_timer;
    logic [CNT_W-1:0] w_timer_nxt;
    logic             r_enable;
    logic             w_enable_nxt;
    logic             r_dir;
    logic             w_dir_nxt;
    logic             r_locked;
    logic             w_locked_nxt;
    logic             w_u;
    logic             w_d;
    logic             w_act;
    logic             w_other;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_up (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_up),
        .btn_db  (w_u)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_dn (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_dn),
        .btn_db  (w_d)
    );

    // The held button is the one matching the last pulsed direction.
    assign w_act   = (r_dir == DIR_UP) ? w_u : w_d;
    assign w_other = (r_dir == DIR_UP) ? w_d : w_u;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_timer  <= '0;
            r_enable <= 1'b0;
            r_dir    <= DIR_UP;
            r_locked <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_timer  <= w_timer_nxt;
            r_enable <= w_enable_nxt;
            r_dir    <= w_dir_nxt;
            r_locked <= w_locked_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_timer_nxt  = (r_timer != '0) ? (r_timer - CNT_W'(1)) : '0;
        w_enable_nxt = 1'b0;
        w_dir_nxt    = r_dir;
        w_locked_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_u && w_d) begin
                    w_state_nxt = ST_LOCK;
                end else if (w_u || w_d) begin
                    w_enable_nxt = 1'b1;
                    w_dir_nxt    = w_u ? DIR_UP : DIR_DN;
                    w_timer_nxt  = CNT_W'(REPEAT_DELAY - 1);
                    w_state_nxt  = ST_DELAY;
                end
            end
            ST_DELAY, ST_REPEAT: begin
                if (!w_act) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_other) begin
                    w_state_nxt = ST_LOCK;
                end else if (r_timer == '0) begin
                    w_enable_nxt = 1'b1;
                    w_timer_nxt  = CNT_W'(REPEAT_PERIOD - 1);
                    w_state_nxt  = ST_REPEAT;
                end
            end
            ST_LOCK: begin
                if (!w_u && !w_d) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        w_locked_nxt = (w_state_nxt == ST_LOCK);
    end

    assign enable    = r_enable;
    assign direction = r_dir;
    assign locked    = r_locked;

endmodule

// File: tb/tb_updown_btn_ctrl.sv
// Scoreboard bench for updown_btn_ctrl: expected pulse cycles are queued at
// stimulus time and matched against enable/direction every cycle.
module tb_updown_btn_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned RD = 8;
    localparam int unsigned RP = 4;

    logic clk    = 1'b0;
    logic rst    = 1'b0;
    logic btn_up = 1'b0;
    logic btn_dn = 1'b0;
    logic enable;
    logic direction;
    logic locked;

    typedef struct {
        int   cyc;
        logic dir;
    } pulse_t;

    pulse_t q[$];
    int     cyc     = 0;
    int     n_chk   = 0;
    int     n_pass  = 0;
    logic   exp_dir = 1'b1;
    logic   mon_exp_en;

    updown_btn_ctrl #(
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP),
        .CNT_W           (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_dn    (btn_dn),
        .enable    (enable),
        .direction (direction),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, obs, exp);
    endtask

    // Every cycle: enable must match the queue head, direction must hold between pulses.
    always @(negedge clk) begin
        if (rst) begin
            mon_exp_en = (q.size() > 0) && (q[0].cyc == cyc);
            if (mon_exp_en) exp_dir = q[0].dir;
            check_eq("enable", int'(enable), int'(mon_exp_en));
            check_eq("direction", int'(direction), int'(exp_dir));
            if (mon_exp_en) void'(q.pop_front());
        end else begin
            exp_dir = 1'b1;
        end
    end

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Raw press of `hold` cycles starting at negedge n: first pulse after edge
    // n+3+DB, repeats while the debounced level (dropping at edge n+hold+2+DB) is high.
    task automatic push_pulses(input int n, input int hold, input logic dir);
        int p;
        int lim;
        bit first;
        if (hold >= int'(DB)) begin
            p     = n + 3 + int'(DB);
            lim   = n + hold + 2 + int'(DB);
            first = 1'b1;
            while (p <= lim) begin
                q.push_back('{p, dir});
                p     = p + (first ? int'(RD) : int'(RP));
                first = 1'b0;
            end
        end
    endtask

    task automatic press(input logic up, input int hold);
        push_pulses(cyc, hold, up);
        if (up) btn_up = 1'b1;
        else    btn_dn = 1'b1;
        repeat (hold) @(negedge clk);
        btn_up = 1'b0;
        btn_dn = 1'b0;
        repeat (DB + 6) @(negedge clk);
    endtask

    initial begin
        int n;
        int t1;

        repeat (3) @(negedge clk);
        check_eq("rst_enable", int'(enable), 0);
        check_eq("rst_direction", int'(direction), 1);
        check_eq("rst_locked", int'(locked), 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);

        press(1'b1, 8);
        press(1'b0, 3);
        press(1'b0, 40);
        press(1'b1, 8);
        press(1'b0, 8);

        // Both held -> LOCK, then asynchronous reset mid-cycle.
        n = cyc;
        btn_up = 1'b1;
        btn_dn = 1'b1;
        wait_until(n + 2 + int'(DB));
        check_eq("both_pre_lock", int'(locked), 0);
        wait_until(n + 3 + int'(DB));
        check_eq("both_locked", int'(locked), 1);
        #2 rst = 1'b0;
        #1;
        check_eq("midrst_enable", int'(enable), 0);
        check_eq("midrst_direction", int'(direction), 1);
        check_eq("midrst_locked", int'(locked), 0);
        btn_dn = 1'b0;
        repeat (3) @(negedge clk);
        n = cyc;
        q.push_back('{n + 3 + int'(DB), 1'b1});
        rst = 1'b1;
        repeat (8) @(negedge clk);
        btn_up = 1'b0;
        repeat (DB + 6) @(negedge clk);

        // Up held, down pressed before the first repeat -> LOCK with no further pulses.
        n = cyc;
        q.push_back('{n + 3 + int'(DB), 1'b1});
        btn_up = 1'b1;
        t1 = n + 3 + int'(DB);
        wait_until(t1);
        btn_dn = 1'b1;
        wait_until(t1 + 2 + int'(DB));
        check_eq("lock_pre", int'(locked), 0);
        wait_until(t1 + 3 + int'(DB));
        check_eq("lock_on", int'(locked), 1);
        wait_until(t1 + 13);
        btn_dn = 1'b0;
        wait_until(t1 + 27);
        check_eq("lock_one_released", int'(locked), 1);
        btn_up = 1'b0;
        wait_until(t1 + 27 + 2 + int'(DB));
        check_eq("lock_hold_last", int'(locked), 1);
        wait_until(t1 + 27 + 3 + int'(DB));
        check_eq("lock_release", int'(locked), 0);
        repeat (10) @(negedge clk);
        check_eq("lock_idle", int'(locked), 0);

        check_eq("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
